// File: rtl/ddr5_dfi_cmd_scheduler_if.sv
// Request/ack handshakes for MRW and write requesters plus the DFI phase-0 command outputs.
// The scheduler connects through the slave modport; requesters and the PHY side use master.
interface ddr5_dfi_cmd_scheduler_if #(
    parameter int pNUM_RANK = 2,
    parameter int pRANK_W   = 1
);
    logic                  mrw_req_i;
    logic [pRANK_W-1:0]    mrw_rank_i;
    logic [7:0]            mrw_mra_i;
    logic [7:0]            mrw_op_i;
    logic                  mrw_ack_o;
    logic                  wr_req_i;
    logic [pRANK_W-1:0]    wr_rank_i;
    logic [8:0]            wr_bank_i;
    logic [13:0]           wr_col_i;
    logic                  wr_bl8_i;
    logic                  wr_ack_o;
    logic [pNUM_RANK-1:0]  dfi_cs_n_o;
    logic [13:0]           dfi_address_o;
    logic                  dfi_wrdata_en_o;
    logic                  busy_o;

    modport slave (
        input  mrw_req_i, mrw_rank_i, mrw_mra_i, mrw_op_i,
        input  wr_req_i, wr_rank_i, wr_bank_i, wr_col_i, wr_bl8_i,
        output mrw_ack_o, wr_ack_o, dfi_cs_n_o, dfi_address_o, dfi_wrdata_en_o, busy_o
    );

    modport master (
        output mrw_req_i, mrw_rank_i, mrw_mra_i, mrw_op_i,
        output wr_req_i, wr_rank_i, wr_bank_i, wr_col_i, wr_bl8_i,
        input  mrw_ack_o, wr_ack_o, dfi_cs_n_o, dfi_address_o, dfi_wrdata_en_o, busy_o
    );
endinterface

// File: rtl/ddr5_dfi_cmd_scheduler.sv
// Round-robin MRW/write command sequencer driving DFI phase 0 at 1:1 ratio.
// Every output is registered from the next-state decode so it lines up with the FSM state.
module ddr5_dfi_cmd_scheduler #(
    parameter int pNUM_RANK = 2,
    parameter int pRANK_W   = 1,
    parameter int pWL       = 4,
    parameter int pTMRW     = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    ddr5_dfi_cmd_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CMD1, CMD2, WAIT} state_t;

    localparam logic [4:0] WL5       = 5'(pWL);
    localparam logic [4:0] TMRW_LAST = 5'(pTMRW - 1);

    state_t                state_reg, state_next;
    logic [4:0]            cnt_reg, cnt_next;
    logic                  is_mrw_reg, is_mrw_next;
    logic                  bl8_reg, bl8_next;
    logic [13:0]           data2_reg, data2_next;
    logic                  rr_mrw_last_reg, rr_mrw_last_next;
    logic [pNUM_RANK-1:0]  cs_n_reg, cs_n_next;
    logic [13:0]           addr_reg, addr_next;
    logic                  wren_reg, wren_next;
    logic                  mrw_ack_reg, mrw_ack_next;
    logic                  wr_ack_reg, wr_ack_next;
    logic                  busy_reg, busy_next;

    logic                  grant_mrw;
    logic [4:0]            wr_end;
    logic                  cmd_done;

    // Tie goes to whichever type was not granted last; MRW wins after reset.
    assign grant_mrw = bus.mrw_req_i && (!bus.wr_req_i || !rr_mrw_last_reg);
    assign wr_end    = 5'(WL5 + (bl8_reg ? 5'd4 : 5'd8));
    assign cmd_done  = is_mrw_reg ? (cnt_reg == TMRW_LAST) : (cnt_reg == 5'(wr_end - 5'd1));

    always_comb begin
        state_next       = state_reg;
        cnt_next         = 5'(cnt_reg + 5'd1);
        is_mrw_next      = is_mrw_reg;
        bl8_next         = bl8_reg;
        data2_next       = data2_reg;
        rr_mrw_last_next = rr_mrw_last_reg;
        cs_n_next        = '1;
        addr_next        = '0;
        mrw_ack_next     = 1'b0;
        wr_ack_next      = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (grant_mrw) begin
                    state_next                = CMD1;
                    is_mrw_next               = 1'b1;
                    rr_mrw_last_next          = 1'b1;
                    data2_next                = {6'b0, bus.mrw_op_i};
                    cs_n_next[bus.mrw_rank_i] = 1'b0;
                    addr_next                 = {1'b0, bus.mrw_mra_i, 5'b00101};
                    mrw_ack_next              = 1'b1;
                end else if (bus.wr_req_i) begin
                    state_next               = CMD1;
                    is_mrw_next              = 1'b0;
                    bl8_next                 = bus.wr_bl8_i;
                    rr_mrw_last_next         = 1'b0;
                    data2_next               = bus.wr_col_i;
                    cs_n_next[bus.wr_rank_i] = 1'b0;
                    addr_next                = {bus.wr_bank_i, 5'b01101};
                    wr_ack_next              = 1'b1;
                end
            end
            CMD1: begin
                state_next = CMD2;
                addr_next  = data2_reg;
            end
            // With pTMRW = 2 an MRW completes straight out of CMD2.
            CMD2:    state_next = cmd_done ? IDLE : WAIT;
            WAIT:    if (cmd_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        wren_next = (state_next == WAIT) && !is_mrw_reg &&
                    (cnt_next >= WL5) && (cnt_next < wr_end);
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            is_mrw_reg      <= 1'b0;
            bl8_reg         <= 1'b0;
            data2_reg       <= '0;
            rr_mrw_last_reg <= 1'b0;
            cs_n_reg        <= '1;
            addr_reg        <= '0;
            wren_reg        <= 1'b0;
            mrw_ack_reg     <= 1'b0;
            wr_ack_reg      <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            is_mrw_reg      <= is_mrw_next;
            bl8_reg         <= bl8_next;
            data2_reg       <= data2_next;
            rr_mrw_last_reg <= rr_mrw_last_next;
            cs_n_reg        <= cs_n_next;
            addr_reg        <= addr_next;
            wren_reg        <= wren_next;
            mrw_ack_reg     <= mrw_ack_next;
            wr_ack_reg      <= wr_ack_next;
            busy_reg        <= busy_next;
        end
    end

    assign bus.dfi_cs_n_o      = cs_n_reg;
    assign bus.dfi_address_o   = addr_reg;
    assign bus.dfi_wrdata_en_o = wren_reg;
    assign bus.mrw_ack_o       = mrw_ack_reg;
    assign bus.wr_ack_o        = wr_ack_reg;
    assign bus.busy_o          = busy_reg;
endmodule
